// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Instruction queue between Fetch and Decode. Fetch pushes {inst, pc}
//   pairs and Decode pops them with a valid/ready handshake. The queue
//   absorbs Decode stalls, and a flush (taken-branch redirect) discards
//   every queued word.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   flush                 redirect pulse; has priority over push and pop
//   in_valid/in_inst/in_pc/in_ready     Fetch side (push = in_valid & in_ready)
//   out_valid/out_inst/out_pc/out_pc4/out_ready  Decode side (pop = out_valid & out_ready)
//   count                 number of valid entries, 0..DEPTH
module fetch_decode_queue #(
    parameter int          DEPTH = 4,
    parameter int          AW    = 2,
    parameter logic [31:0] NOP   = 32'h00000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_inst,
    input  logic [31:0]   in_pc,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_inst,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_pc4,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push, pop;

    // in_ready comes only from registered count, so a full queue refuses a
    // push even when Decode pops in the same cycle.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // A flush discards any same-cycle push and pop.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // First-word fall-through: head is read straight from storage.
    always_comb begin
        out_inst = NOP;
        out_pc   = '0;
        out_pc4  = '0;
        if (out_valid) begin
            out_inst = mem_q[rd_ptr_q].inst;
            out_pc   = mem_q[rd_ptr_q].pc;
            out_pc4  = mem_q[rd_ptr_q].pc + 32'd4;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH == 2**AW.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{inst: in_inst, pc: in_pc};
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_ready = 1'b0;
    logic [2:0]  count;

    fetch_decode_queue #(.DEPTH(DEPTH), .AW(2), .NOP(32'h00000000)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_pc4(out_pc4),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t model[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // Compare every output against the reference queue.
    task automatic check_outputs(input string tag);
        int sz = model.size();
        chk({tag, " out_valid"}, 32'(out_valid), 32'(sz != 0));
        chk({tag, " in_ready"},  32'(in_ready),  32'(sz != DEPTH));
        chk({tag, " count"},     32'(count),     32'(sz));
        chk({tag, " out_inst"},  out_inst, (sz != 0) ? model[0].inst : 32'h0);
        chk({tag, " out_pc"},    out_pc,   (sz != 0) ? model[0].pc   : 32'h0);
        chk({tag, " out_pc4"},   out_pc4,  (sz != 0) ? model[0].pc + 32'd4 : 32'h0);
    endtask

    // One clock: drive inputs, check at negedge, then apply the spec's rules
    // to the model at the rising edge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic ordy, input logic fl);
        bit do_push, do_pop;
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
        @(negedge clk);
        check_outputs(tag);
        do_push = v && (model.size() < DEPTH);
        do_pop  = ordy && (model.size() > 0);
        @(posedge clk);
        if (fl) begin
            model.delete();
        end else begin
            if (do_pop)  void'(model.pop_front());
            if (do_push) model.push_back('{inst: inst, pc: pc});
        end
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // 1. Reset
        #3;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) idle("post_reset");

        // 2. Stream with Decode always ready
        cycle("stream", 1'b1, 32'hA, 32'd0, 1'b1, 1'b0);
        cycle("stream", 1'b1, 32'hB, 32'd4, 1'b1, 1'b0);
        cycle("stream", 1'b1, 32'hC, 32'd8, 1'b1, 1'b0);
        cycle("stream", 1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
        cycle("stream", 1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
        idle("stream_end");

        // 3. Stall until full, fifth push refused, then drain
        for (int i = 0; i < 5; i++)
            cycle("fill", 1'b1, 32'h100 + 32'(i), 32'(16 * i), 1'b0, 1'b0);
        chk("full count", 32'(count), 32'd4);
        chk("full in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 4. Wrap: push/pop pairs through several pointer wraps
        for (int i = 0; i < 11; i++)
            cycle("wrap", 1'b1, 32'h200 + 32'(i), 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
        chk("wrap steady count", 32'(count), 32'd1);
        cycle("wrap", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 4b. pc4 wraps at the top of the address space
        cycle("pc_wrap", 1'b1, 32'hDEAD, 32'hFFFFFFFC, 1'b0, 1'b0);
        chk("pc_wrap pc4", out_pc4, 32'h00000000);
        cycle("pc_wrap", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 5. Flush with a same-cycle push of pc 12
        cycle("flush", 1'b1, 32'h300, 32'd0, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h301, 32'd4, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h302, 32'd8, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h303, 32'd12, 1'b1, 1'b1);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush count", 32'(count), 32'd0);
        cycle("after_flush", 1'b1, 32'h304, 32'd5, 1'b0, 1'b0);
        chk("after_flush pc", out_pc, 32'd5);
        chk("after_flush pc4", out_pc4, 32'd9);
        cycle("after_flush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 6. Async reset between edges with three words queued
        for (int i = 0; i < 3; i++)
            cycle("pre_areset", 1'b1, 32'h400 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model.delete();
        chk("areset out_valid", 32'(out_valid), 32'd0);
        chk("areset count", 32'(count), 32'd0);
        chk("areset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle("post_areset");

        // Random traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, pc,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
